// File: rtl/buf_loader.sv
// Command buffer loader: parses a framed host byte stream into LOAD / START / ABORT
// commands, writes 40-bit command words into the buffer and drives executor control.
module buf_loader #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] buf_addr,
    output logic [39:0] buf_data,
    output logic        buf_wr,
    output logic        exec_start,
    output logic [15:0] exec_start_addr,
    output logic        exec_abort,
    input  logic        exec_complete,
    input  logic [7:0]  exec_error,
    output logic        running,
    output logic [7:0]  last_exec_error,
    output logic [3:0]  err_flags,
    input  logic        clear_errs
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [7:0] HDR_LOAD  = 8'hA5;
    localparam logic [7:0] HDR_START = 8'h5A;
    localparam logic [7:0] HDR_ABORT = 8'h55;

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR0, S_ADDR1, S_CNT0, S_CNT1,
        S_DATA, S_WRITE, S_CSUM, S_SADDR0, S_SADDR1
    } state_t;

    state_t        state, state_nxt;
    logic [TW-1:0] tcnt;
    logic [15:0]   cnt;
    logic [2:0]    idx;
    logic [7:0]    csum;
    logic [7:0]    lo_byte;
    logic          accept;
    logic          timeout;
    logic          start_ok;
    logic          abort_hdr;
    logic [3:0]    err_set;
    logic [5:0]    bsel;

    assign in_ready  = !rst && (state != S_WRITE);
    assign accept    = in_valid && in_ready;
    assign bsel      = {idx, 3'b000};
    assign abort_hdr = (state == S_IDLE) && accept && (in_data == HDR_ABORT);
    // A completion arriving on the same edge frees the executor for this START.
    assign start_ok  = (state == S_SADDR1) && accept && (!running || exec_complete);
    assign timeout   = !accept && (state != S_IDLE) && (state != S_WRITE) &&
                       (tcnt == TW'(TIMEOUT_CYCLES - 1));

    // Error conditions detected this cycle; merged into the sticky flags below.
    always_comb begin
        err_set    = 4'b0000;
        err_set[0] = (state == S_IDLE) && accept && (in_data != HDR_LOAD) &&
                     (in_data != HDR_START) && (in_data != HDR_ABORT);
        err_set[1] = (state == S_CSUM) && accept && (in_data != csum);
        err_set[2] = (state == S_SADDR1) && accept && !start_ok;
        err_set[3] = timeout;
    end

    // Next-state logic: one state per accepted byte, S_WRITE always one cycle.
    always_comb begin
        state_nxt = state;
        if (timeout) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (in_data == HDR_LOAD)       state_nxt = S_ADDR0;
                        else if (in_data == HDR_START) state_nxt = S_SADDR0;
                        else                           state_nxt = S_IDLE;
                    end
                end
                S_ADDR0:  if (accept) state_nxt = S_ADDR1;
                S_ADDR1:  if (accept) state_nxt = S_CNT0;
                S_CNT0:   if (accept) state_nxt = S_CNT1;
                S_CNT1: begin
                    if (accept) state_nxt = ({in_data, cnt[7:0]} == 16'd0) ? S_CSUM : S_DATA;
                end
                S_DATA:   if (accept && idx == 3'd4) state_nxt = S_WRITE;
                S_WRITE:  state_nxt = (cnt == 16'd1) ? S_CSUM : S_DATA;
                S_CSUM:   if (accept) state_nxt = S_IDLE;
                S_SADDR0: if (accept) state_nxt = S_SADDR1;
                S_SADDR1: if (accept) state_nxt = S_IDLE;
                default:  state_nxt = S_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Frame datapath, strobes, executor status and sticky error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            tcnt            <= '0;
            cnt             <= '0;
            idx             <= '0;
            csum            <= '0;
            lo_byte         <= '0;
            buf_addr        <= '0;
            buf_data        <= '0;
            buf_wr          <= 1'b0;
            exec_start      <= 1'b0;
            exec_start_addr <= '0;
            exec_abort      <= 1'b0;
            running         <= 1'b0;
            last_exec_error <= '0;
            err_flags       <= '0;
        end else begin
            buf_wr     <= 1'b0;
            exec_start <= 1'b0;
            exec_abort <= abort_hdr;

            if (accept || timeout || state == S_IDLE || state == S_WRITE) tcnt <= '0;
            else                                                         tcnt <= tcnt + 1'b1;

            case (state)
                S_IDLE: if (accept) begin
                    csum <= '0;
                    idx  <= '0;
                end
                S_ADDR0: if (accept) begin
                    buf_addr[7:0] <= in_data;
                    csum          <= csum ^ in_data;
                end
                S_ADDR1: if (accept) begin
                    buf_addr[15:8] <= in_data;
                    csum           <= csum ^ in_data;
                end
                S_CNT0: if (accept) begin
                    cnt[7:0] <= in_data;
                    csum     <= csum ^ in_data;
                end
                S_CNT1: if (accept) begin
                    cnt[15:8] <= in_data;
                    csum      <= csum ^ in_data;
                end
                S_DATA: if (accept) begin
                    buf_data[bsel +: 8] <= in_data;
                    csum                <= csum ^ in_data;
                    if (idx == 3'd4) begin
                        idx    <= '0;
                        buf_wr <= 1'b1;
                    end else begin
                        idx <= idx + 3'd1;
                    end
                end
                S_WRITE: begin
                    buf_addr <= buf_addr + 16'd1;
                    cnt      <= cnt - 16'd1;
                end
                S_SADDR0: if (accept) lo_byte <= in_data;
                S_SADDR1: if (start_ok) begin
                    exec_start      <= 1'b1;
                    exec_start_addr <= {in_data, lo_byte};
                end
                default: ;
            endcase

            if (start_ok)                        running <= 1'b1;
            else if (exec_complete || abort_hdr) running <= 1'b0;

            if (exec_complete) last_exec_error <= exec_error;

            err_flags <= (clear_errs ? 4'b0000 : err_flags) | err_set;
        end
    end

endmodule

// File: tb/tb_buf_loader.sv
// Directed bench for buf_loader: table of whole frames plus hand-written
// sequences for executor control, timeout, error clearing and reset.
module tb_buf_loader;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] buf_addr;
    logic [39:0] buf_data;
    logic        buf_wr;
    logic        exec_start;
    logic [15:0] exec_start_addr;
    logic        exec_abort;
    logic        exec_complete;
    logic [7:0]  exec_error;
    logic        running;
    logic [7:0]  last_exec_error;
    logic [3:0]  err_flags;
    logic        clear_errs;

    always #5 clk = ~clk;

    buf_loader #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .buf_addr(buf_addr), .buf_data(buf_data), .buf_wr(buf_wr),
        .exec_start(exec_start), .exec_start_addr(exec_start_addr), .exec_abort(exec_abort),
        .exec_complete(exec_complete), .exec_error(exec_error), .running(running),
        .last_exec_error(last_exec_error), .err_flags(err_flags), .clear_errs(clear_errs)
    );

    int checks = 0;
    int passes = 0;

    // Write log and start-pulse counter, sampled on the falling edge.
    logic [15:0] wr_a [64];
    logic [39:0] wr_d [64];
    int          wr_count = 0;
    int          start_count = 0;

    always @(negedge clk) begin
        if (buf_wr && wr_count < 64) begin
            wr_a[wr_count] <= buf_addr;
            wr_d[wr_count] <= buf_data;
            wr_count       <= wr_count + 1;
        end
        if (exec_start) start_count <= start_count + 1;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Offer one byte; returns 1 time unit after the accepting edge.
    task automatic send(input logic [7:0] b, input logic cmp = 1'b0, input logic clr = 1'b0);
        int g;
        @(negedge clk);
        in_data = b; in_valid = 1'b1; exec_complete = cmp; clear_errs = clr;
        g = 0;
        while (!in_ready && g < 20) begin
            @(negedge clk);
            g++;
        end
        if (!in_ready) begin
            checks++;
            $display("FAIL send_ready: in_ready stayed 0, expected 1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0; exec_complete = 1'b0; clear_errs = 1'b0;
    endtask

    task automatic clr_pulse();
        @(negedge clk); clear_errs = 1'b1;
        @(negedge clk); clear_errs = 1'b0;
    endtask

    typedef struct {
        int           len;
        logic [127:0] bytes;  // byte 0 is the most significant of the len bytes
        int           nwr;
        logic [15:0]  a0;
        logic [39:0]  d0;
        logic [15:0]  a1;
        logic [39:0]  d1;
        logic [3:0]   err;
    } vec_t;

    vec_t v [6];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int base;
        int sbase;

        v[0] = '{16, 128'hA5100002_00040302_01400000_000080D6, 2,
                 16'h0010, 40'h4001020304, 16'h0011, 40'h8000000000, 4'b0000};
        v[1] = '{11, 128'hA5FFFF01_00112233_445511, 1,
                 16'hFFFF, 40'h5544332211, 16'h0000, 40'h0, 4'b0010};
        v[2] = '{6, 128'hA5341200_0026, 0,
                 16'h0, 40'h0, 16'h0, 40'h0, 4'b0000};
        v[3] = '{1, 128'h00, 0, 16'h0, 40'h0, 16'h0, 40'h0, 4'b0001};
        v[4] = '{16, 128'hA5FFFF02_00010000_00000200_00000001, 2,
                 16'hFFFF, 40'h0000000001, 16'h0000, 40'h0000000002, 4'b0000};
        v[5] = '{1, 128'h77, 0, 16'h0, 40'h0, 16'h0, 40'h0, 4'b0001};

        rst = 1'b1; in_data = 8'h00; in_valid = 1'b0;
        exec_complete = 1'b0; exec_error = 8'h00; clear_errs = 1'b0;

        // Reset state
        cyc(3);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_buf_wr", buf_wr, 1'b0);
        chk("rst_running", running, 1'b0);
        chk("rst_err", err_flags, 4'h0);
        chk("rst_buf_addr", buf_addr, 16'h0);
        @(negedge clk); rst = 1'b0;
        cyc(1);
        chk("post_rst_in_ready", in_ready, 1'b1);

        // Table of complete frames
        for (int i = 0; i < 6; i++) begin
            clr_pulse();
            base = wr_count;
            for (int k = 0; k < v[i].len; k++)
                send(v[i].bytes[(v[i].len - 1 - k) * 8 +: 8]);
            cyc(3);
            chk($sformatf("v%0d_nwr", i), 64'(wr_count - base), 64'(v[i].nwr));
            if (v[i].nwr > 0) begin
                chk($sformatf("v%0d_a0", i), wr_a[base], v[i].a0);
                chk($sformatf("v%0d_d0", i), wr_d[base], v[i].d0);
            end
            if (v[i].nwr > 1) begin
                chk($sformatf("v%0d_a1", i), wr_a[base + 1], v[i].a1);
                chk($sformatf("v%0d_d1", i), wr_d[base + 1], v[i].d1);
            end
            chk($sformatf("v%0d_err", i), err_flags, v[i].err);
            chk($sformatf("v%0d_ready", i), in_ready, 1'b1);
        end

        // START, rejected second START, completion
        clr_pulse();
        sbase = start_count;
        send(8'h5A); send(8'h10); send(8'h00);
        chk("start_pulse", exec_start, 1'b1);
        chk("start_addr", exec_start_addr, 16'h0010);
        chk("start_running", running, 1'b1);
        cyc(1);
        chk("start_pulse_end", exec_start, 1'b0);
        chk("start_count1", 64'(start_count - sbase), 64'd1);
        send(8'h5A); send(8'h20); send(8'h00);
        cyc(2);
        chk("start2_count", 64'(start_count - sbase), 64'd1);
        chk("start2_err", err_flags, 4'b0100);
        chk("start2_running", running, 1'b1);
        @(negedge clk); exec_complete = 1'b1; exec_error = 8'h05;
        @(negedge clk); exec_complete = 1'b0; exec_error = 8'h00;
        chk("cmpl_running", running, 1'b0);
        chk("cmpl_error", last_exec_error, 8'h05);

        // Completion on the same edge as a START acceptance
        clr_pulse();
        send(8'h5A); send(8'h40); send(8'h00);
        chk("run_again", running, 1'b1);
        send(8'h5A); send(8'h30); send(8'h00, 1'b1);
        chk("same_start", exec_start, 1'b1);
        chk("same_addr", exec_start_addr, 16'h0030);
        chk("same_running", running, 1'b1);
        chk("same_err", err_flags, 4'b0000);
        chk("same_lasterr", last_exec_error, 8'h00);

        // ABORT while running
        send(8'h55);
        chk("abort_pulse", exec_abort, 1'b1);
        chk("abort_running", running, 1'b0);
        cyc(1);
        chk("abort_end", exec_abort, 1'b0);

        // Timeout after 3 data bytes
        clr_pulse();
        base = wr_count;
        send(8'hA5); send(8'h00); send(8'h01); send(8'h02); send(8'h00);
        send(8'h01); send(8'h02); send(8'h03);
        cyc(10);
        chk("to_early", err_flags, 4'b0000);
        cyc(8);
        chk("to_err", err_flags, 4'b1000);
        chk("to_nwr", 64'(wr_count - base), 64'd0);
        send(8'h00);
        cyc(1);
        chk("to_idle", err_flags, 4'b1001);
        send(8'h00, 1'b0, 1'b1);
        cyc(1);
        chk("clr_same_edge", err_flags, 4'b0001);
        clr_pulse();
        cyc(1);
        chk("clr_all", err_flags, 4'b0000);

        // Reset in the middle of a LOAD
        @(negedge clk); exec_complete = 1'b1; exec_error = 8'h09;
        @(negedge clk); exec_complete = 1'b0; exec_error = 8'h00;
        send(8'h5A); send(8'h50); send(8'h00);
        send(8'h00);
        base = wr_count;
        send(8'hA5); send(8'h00); send(8'h02); send(8'h01); send(8'h00);
        send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
        @(negedge clk); rst = 1'b1;
        cyc(1);
        chk("mr_in_ready", in_ready, 1'b0);
        chk("mr_buf_wr", buf_wr, 1'b0);
        chk("mr_buf_addr", buf_addr, 16'h0);
        chk("mr_buf_data", buf_data, 40'h0);
        chk("mr_start_addr", exec_start_addr, 16'h0);
        chk("mr_running", running, 1'b0);
        chk("mr_lasterr", last_exec_error, 8'h00);
        chk("mr_err", err_flags, 4'h0);
        chk("mr_strobes", {exec_start, exec_abort}, 2'b00);
        @(negedge clk); rst = 1'b0;
        send(8'hEE);
        cyc(3);
        chk("mr_nwr", 64'(wr_count - base), 64'd0);
        chk("mr_idle_hdr", err_flags, 4'b0001);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
